// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: FSM state encoding and default sizing constants shared by the
// clock meter and its synchronizer front end.
package clk_meter_pkg;

    localparam int DEF_CNT_W       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

endpackage

// File: rtl/clk_meter_sync.sv
// clk_meter_sync: brings the asynchronous clk_in into the clk domain through a
// SYNC_STAGES-deep flop chain, keeps one cycle of history and flags the
// synchronized rising and falling edges.
module clk_meter_sync
    import clk_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clk_in,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Metastability chain followed by the edge-history flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_clk_in};
            r_prev <= w_sync;
        end
    end

    assign o_rise = w_sync & ~r_prev;
    assign o_fall = ~w_sync & r_prev;

endmodule

// File: rtl/clk_meter.sv
// clk_meter: measures the period and high time of an external clock in
// system-clock cycles and publishes them as a divider-style limit (period-1)
// and a duty count. Periods that saturate the counter raise an ovf pulse
// instead of a measurement.
// Optional feature: define CLK_METER_AVG_EN to publish the average of the
// current and previous raw measurements (first result after IDLE/ovf is raw).
module clk_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             en,
    output logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] duty,
    output logic             meas_valid,
    output logic             ovf,
    output logic             locked
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_rise;
    logic             w_fall;
    state_t           r_state;
    state_t           w_state_next;
    logic             w_start;
    logic             w_publish;
    logic             w_ovf_hit;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi;
    logic             r_ovf_pend;
    logic [CNT_W-1:0] w_limit_new;
    logic [CNT_W-1:0] w_duty_new;
    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] r_duty;
    logic             r_meas_valid;
    logic             r_ovf;
    logic             r_locked;

    clk_meter_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .i_clk_in (clk_in),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    // Next state plus the per-cycle event strobes that steer the datapath.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_publish    = 1'b0;
        w_ovf_hit    = 1'b0;
        if (!en) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_next = ST_MEAS;
                        w_start      = 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (w_rise) begin
                        if (r_ovf_pend) w_ovf_hit = 1'b1;
                        else            w_publish = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Period/high counters; every rise restarts a period at 1, and the period
    // counter saturates, remembering that the period is too long.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_ovf_pend <= 1'b0;
        end else if (w_start || w_publish || w_ovf_hit) begin
            r_cnt      <= CNT_ONE;
            r_hi       <= '0;
            r_ovf_pend <= 1'b0;
        end else if (en && r_state == ST_MEAS) begin
            if (w_fall) r_hi <= r_cnt;
            if (r_cnt == CNT_MAX) r_ovf_pend <= 1'b1;
            else                  r_cnt      <= r_cnt + CNT_ONE;
        end
    end

`ifdef CLK_METER_AVG_EN
    logic [CNT_W-1:0] r_prev_period;
    logic [CNT_W-1:0] r_prev_hi;
    logic             r_hist_valid;
    logic [CNT_W:0]   w_sum_period;
    logic [CNT_W:0]   w_sum_hi;

    assign w_sum_period = {1'b0, r_prev_period} + {1'b0, r_cnt};
    assign w_sum_hi     = {1'b0, r_prev_hi} + {1'b0, r_hi};
    // Both sums are at least 2, so halving then subtracting one cannot wrap.
    assign w_limit_new  = r_hist_valid ? (w_sum_period[CNT_W:1] - CNT_ONE) : (r_cnt - CNT_ONE);
    assign w_duty_new   = r_hist_valid ? w_sum_hi[CNT_W:1] : r_hi;

    // History of the last published raw measurement; dropped on IDLE or ovf.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev_period <= '0;
            r_prev_hi     <= '0;
            r_hist_valid  <= 1'b0;
        end else if (!en || w_ovf_hit) begin
            r_hist_valid  <= 1'b0;
        end else if (w_publish) begin
            r_prev_period <= r_cnt;
            r_prev_hi     <= r_hi;
            r_hist_valid  <= 1'b1;
        end
    end
`else
    // cnt is at least 1 whenever a rise is seen, so cnt-1 never wraps.
    assign w_limit_new = r_cnt - CNT_ONE;
    assign w_duty_new  = r_hi;
`endif

    // Published results, single-cycle pulses and the lock flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_limit      <= '0;
            r_duty       <= '0;
            r_meas_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_meas_valid <= w_publish;
            r_ovf        <= w_ovf_hit;
            if (w_publish) begin
                r_limit  <= w_limit_new;
                r_duty   <= w_duty_new;
                r_locked <= 1'b1;
            end else if (w_ovf_hit || !en) begin
                r_locked <= 1'b0;
            end
        end
    end

    assign limit      = r_limit;
    assign duty       = r_duty;
    assign meas_valid = r_meas_valid;
    assign ovf        = r_ovf;
    assign locked     = r_locked;

endmodule
